// File: rtl/c3lib_sync_glitch_filter_edge.sv
// Glitch filter for an already-synchronized level. It emits one-cycle rise/fall pulses and keeps a
// saturating count of accepted edges. Define C3LIB_SYNC_FILT_STICKY_EN to add sticky edge flags.
module c3lib_sync_glitch_filter_edge #(
    parameter int unsigned FILT_CYC  = 4,
    parameter int unsigned CNT_W     = 8,
    parameter bit          RESET_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    input  logic             cnt_clr,
`ifdef C3LIB_SYNC_FILT_STICKY_EN
    input  logic             sticky_clr,
    output logic             rise_sticky,
    output logic             fall_sticky,
`endif
    output logic             data_out,
    output logic             rise_pls,
    output logic             fall_pls,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int unsigned    FltW    = $clog2(FILT_CYC + 1);
    localparam logic [FltW-1:0] FltLast = FltW'(FILT_CYC - 1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        StableLo,
        PendHi,
        StableHi,
        PendLo
    } state_e;

    localparam state_e StReset = RESET_VAL ? StableHi : StableLo;

    state_e           state_q, state_d;
    logic [FltW-1:0]  flt_cnt_q, flt_cnt_d;
    logic             data_out_q, data_out_d;
    logic             rise_pls_q, rise_pls_d;
    logic             fall_pls_q, fall_pls_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             commit_rise, commit_fall;

    always_comb begin
        state_d     = state_q;
        flt_cnt_d   = flt_cnt_q;
        commit_rise = 1'b0;
        commit_fall = 1'b0;
        unique case (state_q)
            StableLo: begin
                if (data_in) begin
                    if (FILT_CYC == 1) begin
                        state_d     = StableHi;
                        commit_rise = 1'b1;
                    end else begin
                        state_d   = PendHi;
                        flt_cnt_d = FltW'(1);
                    end
                end
            end
            PendHi: begin
                if (!data_in) begin
                    state_d   = StableLo;
                    flt_cnt_d = '0;
                end else if (flt_cnt_q == FltLast) begin
                    state_d     = StableHi;
                    flt_cnt_d   = '0;
                    commit_rise = 1'b1;
                end else begin
                    flt_cnt_d = flt_cnt_q + FltW'(1);
                end
            end
            StableHi: begin
                if (!data_in) begin
                    if (FILT_CYC == 1) begin
                        state_d     = StableLo;
                        commit_fall = 1'b1;
                    end else begin
                        state_d   = PendLo;
                        flt_cnt_d = FltW'(1);
                    end
                end
            end
            PendLo: begin
                if (data_in) begin
                    state_d   = StableHi;
                    flt_cnt_d = '0;
                end else if (flt_cnt_q == FltLast) begin
                    state_d     = StableLo;
                    flt_cnt_d   = '0;
                    commit_fall = 1'b1;
                end else begin
                    flt_cnt_d = flt_cnt_q + FltW'(1);
                end
            end
            default: begin
                state_d   = StReset;
                flt_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        data_out_d = data_out_q;
        if (commit_rise) begin
            data_out_d = 1'b1;
        end else if (commit_fall) begin
            data_out_d = 1'b0;
        end
        rise_pls_d = commit_rise;
        fall_pls_d = commit_fall;
        // Clear beats a coincident commit; the count saturates rather than wrapping.
        edge_cnt_d = edge_cnt_q;
        if (cnt_clr) begin
            edge_cnt_d = '0;
        end else if ((commit_rise || commit_fall) && (edge_cnt_q != CntMax)) begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StReset;
            flt_cnt_q  <= '0;
            data_out_q <= RESET_VAL;
            rise_pls_q <= 1'b0;
            fall_pls_q <= 1'b0;
            edge_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            flt_cnt_q  <= flt_cnt_d;
            data_out_q <= data_out_d;
            rise_pls_q <= rise_pls_d;
            fall_pls_q <= fall_pls_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign data_out = data_out_q;
    assign rise_pls = rise_pls_q;
    assign fall_pls = fall_pls_q;
    assign edge_cnt = edge_cnt_q;

`ifdef C3LIB_SYNC_FILT_STICKY_EN
    logic rise_sticky_q, rise_sticky_d;
    logic fall_sticky_q, fall_sticky_d;

    // Flags follow the visible pulse; a set in the same cycle as sticky_clr wins.
    always_comb begin
        rise_sticky_d = rise_pls_q | (rise_sticky_q & ~sticky_clr);
        fall_sticky_d = fall_pls_q | (fall_sticky_q & ~sticky_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_sticky_q <= 1'b0;
            fall_sticky_q <= 1'b0;
        end else begin
            rise_sticky_q <= rise_sticky_d;
            fall_sticky_q <= fall_sticky_d;
        end
    end

    assign rise_sticky = rise_sticky_q;
    assign fall_sticky = fall_sticky_q;
`endif

endmodule

// File: tb/tb_c3lib_sync_glitch_filter_edge.sv
// Bench for c3lib_sync_glitch_filter_edge: two configurations against a run-length model.
module tb_c3lib_sync_glitch_filter_edge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, data_in, cnt_clr, sticky_clr;
    logic dout0, rp0, fp0;
    logic [1:0] ec0;
    logic dout1, rp1, fp1;
    logic [2:0] ec1;
`ifdef C3LIB_SYNC_FILT_STICKY_EN
    logic rs0, fs0, rs1, fs1;
`endif

    c3lib_sync_glitch_filter_edge #(.FILT_CYC(4), .CNT_W(2), .RESET_VAL(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .cnt_clr(cnt_clr),
`ifdef C3LIB_SYNC_FILT_STICKY_EN
        .sticky_clr(sticky_clr), .rise_sticky(rs0), .fall_sticky(fs0),
`endif
        .data_out(dout0), .rise_pls(rp0), .fall_pls(fp0), .edge_cnt(ec0)
    );

    c3lib_sync_glitch_filter_edge #(.FILT_CYC(1), .CNT_W(3), .RESET_VAL(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .cnt_clr(cnt_clr),
`ifdef C3LIB_SYNC_FILT_STICKY_EN
        .sticky_clr(sticky_clr), .rise_sticky(rs1), .fall_sticky(fs1),
`endif
        .data_out(dout1), .rise_pls(rp1), .fall_pls(fp1), .edge_cnt(ec1)
    );

    int checks = 0;
    int errors = 0;

    // Model: accept a new level once FILT_CYC consecutive samples differ from the current one.
    int m_filt [2] = '{4, 1};
    int m_max  [2] = '{3, 7};
    int m_rv   [2] = '{0, 1};
    int m_lvl  [2];
    int m_run  [2];
    int m_rp   [2];
    int m_fp   [2];
    int m_cnt  [2];
    int m_rs   [2];
    int m_fs   [2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input int i);
        int commit;
        if (rst) begin
            m_lvl[i] = m_rv[i];
            m_run[i] = 0;
            m_rp[i]  = 0;
            m_fp[i]  = 0;
            m_cnt[i] = 0;
            m_rs[i]  = 0;
            m_fs[i]  = 0;
        end else begin
            m_rs[i] = (m_rp[i] != 0 || (m_rs[i] != 0 && !sticky_clr)) ? 1 : 0;
            m_fs[i] = (m_fp[i] != 0 || (m_fs[i] != 0 && !sticky_clr)) ? 1 : 0;
            commit  = 0;
            m_rp[i] = 0;
            m_fp[i] = 0;
            if (int'(data_in) != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] >= m_filt[i]) begin
                    m_lvl[i] = int'(data_in);
                    m_run[i] = 0;
                    commit   = 1;
                    m_rp[i]  = int'(data_in);
                    m_fp[i]  = int'(!data_in);
                end
            end else begin
                m_run[i] = 0;
            end
            if (cnt_clr) m_cnt[i] = 0;
            else if (commit != 0 && m_cnt[i] < m_max[i]) m_cnt[i]++;
        end
    endtask

    task automatic step(input logic r, input logic d, input logic c, input logic s);
        @(negedge clk);
        rst        = r;
        data_in    = d;
        cnt_clr    = c;
        sticky_clr = s;
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        chk("f4 data_out", int'(dout0), m_lvl[0]);
        chk("f4 rise_pls", int'(rp0), m_rp[0]);
        chk("f4 fall_pls", int'(fp0), m_fp[0]);
        chk("f4 edge_cnt", int'(ec0), m_cnt[0]);
        chk("f1 data_out", int'(dout1), m_lvl[1]);
        chk("f1 rise_pls", int'(rp1), m_rp[1]);
        chk("f1 fall_pls", int'(fp1), m_fp[1]);
        chk("f1 edge_cnt", int'(ec1), m_cnt[1]);
`ifdef C3LIB_SYNC_FILT_STICKY_EN
        chk("f4 rise_sticky", int'(rs0), m_rs[0]);
        chk("f4 fall_sticky", int'(fs0), m_fs[0]);
        chk("f1 rise_sticky", int'(rs1), m_rs[1]);
        chk("f1 fall_sticky", int'(fs1), m_fs[1]);
`endif
    endtask

    initial begin
        logic d;
        int   len;
        rst        = 1'b1;
        data_in    = 1'b0;
        cnt_clr    = 1'b0;
        sticky_clr = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit reset data_out f4", int'(dout0), 0);
        chk("lit reset data_out f1", int'(dout1), 1);
        chk("lit reset edge_cnt", int'(ec0), 0);

        // Quiet low input: nothing should happen on the 4-cycle filter.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk("lit quiet pulses", int'(rp0 | fp0), 0);
        end
        chk("lit quiet edge_cnt", int'(ec0), 0);

        // Held high: accepted on the 4th sample.
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            chk("lit rise data_out", int'(dout0), (j == 3) ? 1 : 0);
            chk("lit rise pulse", int'(rp0), (j == 3) ? 1 : 0);
        end
        chk("lit rise edge_cnt", int'(ec0), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("lit rise pulse width", int'(rp0), 0);

        // 3-cycle low glitch is rejected, 4-cycle low is accepted.
        for (int j = 0; j < 3; j++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk("lit glitch data_out", int'(dout0), 1);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("lit glitch fall", int'(fp0), 0);
        for (int j = 0; j < 4; j++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit fall pulse", int'(fp0), 1);
        chk("lit fall edge_cnt", int'(ec0), 2);

        // Reset while pending with two high samples counted.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("lit rst data_out", int'(dout0), 0);
        chk("lit rst rise", int'(rp0), 0);
        chk("lit rst edge_cnt", int'(ec0), 0);
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            chk("lit post-rst data_out", int'(dout0), (j == 3) ? 1 : 0);
        end

        // Saturation at 3 with 8-cycle half periods, then clear coincident with a commit.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("lit clr edge_cnt", int'(ec0), 0);
        for (int e = 0; e < 6; e++) begin
            for (int j = 0; j < 8; j++) begin
                step(1'b0, (e % 2 == 0) ? 1'b0 : 1'b1, (e == 5 && j == 3) ? 1'b1 : 1'b0, 1'b0);
                if (j == 3) begin
                    chk("lit sat pulse", int'(rp0 | fp0), 1);
                    chk("lit sat edge_cnt", int'(ec0), (e == 5) ? 0 : ((e + 1 > 3) ? 3 : e + 1));
                end
            end
        end

        // Randomized run lengths around the filter threshold.
        d = 1'b0;
        for (int n = 0; n < 600; n++) begin
            d   = ~d;
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) begin
                step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, d,
                     ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
                if (rp0 && fp0) chk("f4 rise&fall exclusive", 1, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
